bnn_sequencer: RTL and testbench

BNN_SEQUENCER -- requirements
Module: bnn_sequencer

---
 rtl/bnn_sequencer_if.sv | 22 ++
 rtl/bnn_sequencer.sv | 145 ++++++++++++++
 tb/tb_bnn_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bnn_sequencer_if.sv
// Handshake and weight-load bus of the BNN sequencer.
interface bnn_sequencer_if;
  logic       start;
  logic [7:0] x_in;
  logic       load_en;
  logic [3:0] load_nib;
  logic       ready;
  logic       busy;
  logic [3:0] result;
  logic       result_valid;
  logic [3:0] load_ptr;

  modport master (
    output start, x_in, load_en, load_nib,
    input  ready, busy, result, result_valid, load_ptr
  );

  modport slave (
    input  start, x_in, load_en, load_nib,
    output ready, busy, result, result_valid, load_ptr
  );
endinterface

// File: rtl/bnn_sequencer.sv
// Two-layer binary neural net (8 hidden + 4 output neurons) sharing one XNOR-popcount unit.
// Optional macro BNN_SEQ_THRESH_PROG_EN adds load slot 12, which programs the threshold.
module bnn_sequencer #(
  parameter logic [3:0] THRESH = 4'd7
) (
  input logic            clk,
  input logic            reset,
  bnn_sequencer_if.slave bus
);
  localparam int unsigned N_NEURON = 12;
  localparam int unsigned VEC_W    = 8;
  localparam int unsigned SUM_W    = 4;
`ifdef BNN_SEQ_THRESH_PROG_EN
  localparam logic [3:0] LAST_SLOT = 4'd12;
`else
  localparam logic [3:0] LAST_SLOT = 4'd11;
`endif
  localparam logic [VEC_W-1:0] W_RST [N_NEURON] = '{
    8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07,
    8'hFF, 8'h00, 8'h83, 8'h0C, 8'h30, 8'h80
  };

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       idx, idx_nxt;
  logic             accept_c;
  logic [VEC_W-1:0] x_reg;
  logic [VEC_W-1:0] h;
  logic [VEC_W-1:0] w [N_NEURON];
  logic [3:0]       thr;
  logic [3:0]       pending;
  logic             nib_hi;
  logic [3:0]       load_ptr_r;
  logic [3:0]       result_r;
  logic             ready_r, busy_r, valid_r;
  logic             load_do_c;

  logic [VEC_W-1:0] vec_c, match_c;
  logic [SUM_W-1:0] sum_c;
  logic             neuron_bit_c;

  // Shared XNOR-popcount neuron; layer 2 feeds back the hidden vector.
  always_comb begin
    vec_c   = (state == L2) ? h : x_reg;
    match_c = ~(vec_c ^ w[idx]);
    sum_c   = '0;
    for (int i = 0; i < int'(VEC_W); i++) begin
      sum_c = sum_c + SUM_W'(match_c[i]);
    end
    neuron_bit_c = (sum_c >= thr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = L1;
          idx_nxt   = '0;
          accept_c  = 1'b1;
        end
      end
      L1: begin
        idx_nxt = idx + 4'd1;
        if (idx == 4'd7) state_nxt = L2;
      end
      L2: begin
        idx_nxt = idx + 4'd1;
        if (idx == 4'd11) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // start has priority over a weight nibble arriving in the same IDLE cycle.
  assign load_do_c = (state == IDLE) && bus.load_en && !bus.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg      <= '0;
      h          <= '0;
      result_r   <= '0;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      pending    <= '0;
      nib_hi     <= 1'b0;
      load_ptr_r <= '0;
      for (int i = 0; i < int'(N_NEURON); i++) w[i] <= W_RST[i];
    end else begin
      ready_r <= (state_nxt == IDLE);
      busy_r  <= (state_nxt != IDLE);
      valid_r <= (state_nxt == DONE);
      if (accept_c) x_reg <= bus.x_in;
      if (state == L1) h[idx[2:0]] <= neuron_bit_c;
      if (state == L2) result_r[idx[1:0]] <= neuron_bit_c;
      if (load_do_c) begin
        if (!nib_hi) begin
          pending <= bus.load_nib;
          nib_hi  <= 1'b1;
        end else begin
          nib_hi     <= 1'b0;
          load_ptr_r <= (load_ptr_r == LAST_SLOT) ? 4'd0 : load_ptr_r + 4'd1;
          if (load_ptr_r < 4'(N_NEURON)) w[load_ptr_r] <= {bus.load_nib, pending};
        end
      end
    end
  end

`ifdef BNN_SEQ_THRESH_PROG_EN
  // Completing slot 12 programs the threshold from its low nibble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr <= THRESH;
    end else if (load_do_c && nib_hi && (load_ptr_r == LAST_SLOT)) begin
      thr <= pending;
    end
  end
`else
  assign thr = THRESH;
`endif

  assign bus.ready        = ready_r;
  assign bus.busy         = busy_r;
  assign bus.result       = result_r;
  assign bus.result_valid = valid_r;
  assign bus.load_ptr     = load_ptr_r;
endmodule

// File: tb/tb_bnn_sequencer.sv
// Self-checking bench for bnn_sequencer: fixed vectors, corner sequences, random vs. model.
module tb_bnn_sequencer;
`ifdef BNN_SEQ_THRESH_PROG_EN
  localparam int NSLOT = 13;
`else
  localparam int NSLOT = 12;
`endif
  localparam logic [7:0] W_RST [12] = '{
    8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07,
    8'hFF, 8'h00, 8'h83, 8'h0C, 8'h30, 8'h80
  };

  typedef struct {
    logic [7:0] x;
    logic [3:0] res;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] mw [12];
  int         mptr;
  logic [3:0] mthr;

  always #5 clk = ~clk;

  bnn_sequencer_if bus ();
  bnn_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference network: straight from the neuron definition, no notion of time.
  function automatic logic [3:0] model(input logic [7:0] x);
    logic [7:0] hh;
    logic [3:0] r;
    for (int n = 0; n < 8; n++) hh[n] = ($countones(~(x ^ mw[n])) >= int'(mthr));
    for (int n = 8; n < 12; n++) r[n-8] = ($countones(~(hh ^ mw[n])) >= int'(mthr));
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 12; i++) mw[i] = W_RST[i];
    mptr = 0;
    mthr = 4'd7;
  endtask

  task automatic do_reset();
    bus.start = 1'b0; bus.load_en = 1'b0; bus.x_in = '0; bus.load_nib = '0;
    reset = 1'b1;
    step(); step();
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_load_ptr", 32'(bus.load_ptr), 32'd0);
    reset = 1'b0;
    model_reset();
    step();
  endtask

  task automatic send_nib(input logic [3:0] n);
    bus.load_en = 1'b1; bus.load_nib = n;
    step();
    bus.load_en = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    send_nib(b[3:0]);
    send_nib(b[7:4]);
    if (mptr < 12) mw[mptr] = b; else mthr = b[3:0];
    mptr = (mptr + 1) % NSLOT;
  endtask

  // One inference; k counts rising edges after the accepting edge.
  task automatic run_inf(input logic [7:0] x, input logic [3:0] exp, input bit use_exp,
                         input bit poke, input bit flip, input bit with_load, input string name);
    int pulses = 0;
    logic [3:0] mres;
    mres = model(x);
    bus.x_in = x; bus.start = 1'b1;
    if (with_load) begin bus.load_en = 1'b1; bus.load_nib = 4'hC; end
    step();
    bus.start = 1'b0; bus.load_en = 1'b0;
    if (flip) bus.x_in = 8'hFF;
    for (int k = 1; k <= 14; k++) begin
      if (poke) begin
        bus.start   = (k >= 3 && k <= 6);
        bus.load_en = (k >= 3 && k <= 6);
        bus.load_nib = 4'hA;
      end
      step();
      if (bus.result_valid) pulses++;
      check({name, "_valid"}, 32'(bus.result_valid), 32'(k == 12));
      check({name, "_busy"}, 32'(bus.busy), 32'(k <= 12));
      check({name, "_ready"}, 32'(bus.ready), 32'(k >= 13));
      if (k == 12) begin
        check({name, "_model"}, 32'(bus.result), 32'(mres));
        if (use_exp) check({name, "_result"}, 32'(bus.result), 32'(exp));
      end
    end
    bus.start = 1'b0; bus.load_en = 1'b0;
    check({name, "_pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    vec_t tbl [4];
    tbl[0] = '{x: 8'h00, res: 4'b1000};
    tbl[1] = '{x: 8'hFF, res: 4'b0000};
    tbl[2] = '{x: 8'hE0, res: 4'b0000};
    tbl[3] = '{x: 8'h00, res: 4'b1000};

    reset = 1'b1;
    bus.start = 1'b0; bus.load_en = 1'b0; bus.x_in = '0; bus.load_nib = '0;
    do_reset();

    for (int i = 0; i < 4; i++) run_inf(tbl[i].x, tbl[i].res, 1'b1, 1'b0, 1'b0, 1'b0, "tbl");

    // Input captured at accept only.
    run_inf(8'h00, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, "xflip");

    // start/load_en while busy are ignored.
    run_inf(8'h00, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, "poke");
    check("poke_load_ptr", 32'(bus.load_ptr), 32'd0);

    // Pending low nibble survives a start+load_en collision.
    send_nib(4'h5);
    run_inf(8'h00, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, "collide");
    send_nib(4'h8);
    mw[0] = 8'h85; mptr = 1;
    check("collide_load_ptr", 32'(bus.load_ptr), 32'd1);
    run_inf(8'h3C, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, "collide_chk");

    // Full 24-nibble reload, output weights all 80.
    do_reset();
    for (int i = 0; i < 8; i++) load_byte(W_RST[i]);
    for (int i = 8; i < 12; i++) load_byte(8'h80);
    check("reload_load_ptr", 32'(bus.load_ptr), 32'(mptr));
    run_inf(8'h00, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "reload");

    // Reset in the middle of an inference.
    do_reset();
    bus.x_in = 8'h00; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    reset = 1'b1;
    #1;
    check("abort_valid_async", 32'(bus.result_valid), 32'd0);
    step();
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      check("abort_no_valid", 32'(bus.result_valid), 32'd0);
    end
    run_inf(8'h00, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, "after_abort");

    // Random weight loads and inputs against the model.
    do_reset();
    for (int it = 0; it < 25; it++) begin
      int nb = $urandom_range(0, 4);
      for (int b = 0; b < nb; b++) load_byte(8'($urandom));
      check("rnd_load_ptr", 32'(bus.load_ptr), 32'(mptr));
      run_inf(8'($urandom), 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rnd");
    end

`ifdef BNN_SEQ_THRESH_PROG_EN
    do_reset();
    for (int i = 0; i < 12; i++) load_byte(W_RST[i]);
    load_byte(8'h03);
    check("thr_load_ptr", 32'(bus.load_ptr), 32'd0);
    run_inf(8'h00, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, "thr_prog");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
